// File: rtl/seg7_pkg.sv
// seg7_pkg: digit-byte field layout, idle pin values and the hex-to-segment table
package seg7_pkg;
  localparam int HEX_LSB   = 0;
  localparam int DP_BIT    = 4;
  localparam int BLANK_BIT = 5;
  localparam logic [7:0] SEG_OFF  = 8'hFF;
  localparam logic [3:0] SEL_NONE = 4'hF;
  function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
    case (h)
      4'h0: hex_to_seg = 7'h3F;
      4'h1: hex_to_seg = 7'h06;
      4'h2: hex_to_seg = 7'h5B;
      4'h3: hex_to_seg = 7'h4F;
      4'h4: hex_to_seg = 7'h66;
      4'h5: hex_to_seg = 7'h6D;
      4'h6: hex_to_seg = 7'h7D;
      4'h7: hex_to_seg = 7'h07;
      4'h8: hex_to_seg = 7'h7F;
      4'h9: hex_to_seg = 7'h6F;
      4'hA: hex_to_seg = 7'h77;
      4'hB: hex_to_seg = 7'h7C;
      4'hC: hex_to_seg = 7'h39;
      4'hD: hex_to_seg = 7'h5E;
      4'hE: hex_to_seg = 7'h79;
      default: hex_to_seg = 7'h71;
    endcase
  endfunction
endpackage

// File: rtl/seg7_hex_decode.sv
// seg7_hex_decode: one digit field to active-low segment pins, honouring blank, dp and PWM phase
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [5:0] i_byte,
  input  logic       i_lit,
  output logic [7:0] o_seg
);
  assign o_seg = (i_byte[BLANK_BIT] || !i_lit) ? SEG_OFF
               : {~i_byte[DP_BIT], ~hex_to_seg(i_byte[HEX_LSB +: 4])};
endmodule

// File: rtl/seg7_scan_mux.sv
// seg7_scan_mux: 4-digit common-anode scanner with frame snapshot, dead-time blanking and PWM dimming
module seg7_scan_mux
  import seg7_pkg::*;
#(
  parameter int PRESCALE    = 25000,
  parameter int DEAD_CYCLES = 16
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic [7:0] IN_A,
  input  logic [7:0] IN_B,
  input  logic [7:0] IN_C,
  input  logic [7:0] IN_D,
  input  logic [3:0] BRIGHT,
  output logic [3:0] SEG_SELECT,
  output logic [7:0] DEC_OUT,
  output logic       FRAME_TICK
);
  localparam int CW = $clog2(PRESCALE);
  logic [CW-1:0]     r_slot;
  logic [1:0]        r_idx;
  logic [3:0]        r_pwm;
  logic [3:0][5:0]   r_sh;
  logic [3:0]        r_bright_sh;
  logic              r_load_pend;
  logic              w_slot_end;
  logic              w_snap;
  logic              w_dead;
  logic              w_lit;
  logic [7:0]        w_dec;
  logic              w_unused;
  assign w_unused   = &{1'b0, IN_A[7:6], IN_B[7:6], IN_C[7:6], IN_D[7:6]};
  assign w_slot_end = r_slot == CW'(PRESCALE - 1);
  assign w_snap     = (w_slot_end && r_idx == 2'd3) || r_load_pend;
  assign w_dead     = int'(r_slot) < DEAD_CYCLES;
  assign w_lit      = (r_pwm < r_bright_sh) || (r_bright_sh == 4'hF);
  seg7_hex_decode u_dec (
    .i_byte (r_sh[r_idx]),
    .i_lit  (w_lit),
    .o_seg  (w_dec)
  );
  // Counters hold on the post-reset load edge so the first frame is a full 4*PRESCALE long
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_slot      <= '0;
      r_idx       <= '0;
      r_pwm       <= '0;
      r_sh        <= '0;
      r_bright_sh <= '0;
      r_load_pend <= 1'b1;
      SEG_SELECT  <= SEL_NONE;
      DEC_OUT     <= SEG_OFF;
      FRAME_TICK  <= 1'b0;
    end else begin
      r_pwm      <= r_pwm + 4'd1;
      FRAME_TICK <= w_snap;
      if (w_snap) begin
        r_sh        <= {IN_D[5:0], IN_C[5:0], IN_B[5:0], IN_A[5:0]};
        r_bright_sh <= BRIGHT;
        r_load_pend <= 1'b0;
      end
      if (!r_load_pend) begin
        r_slot <= w_slot_end ? '0 : r_slot + CW'(1);
        r_idx  <= w_slot_end ? r_idx + 2'd1 : r_idx;
      end
      SEG_SELECT <= w_dead ? SEL_NONE : ~(4'b0001 << r_idx);
      DEC_OUT    <= w_dead ? SEG_OFF : w_dec;
    end
  end
endmodule
